// File: rtl/cart_motion_controller.sv
// Cart kinematics integrator: turns operation/boost event pulses into heading, signed speed and
// clamped 2-D position on a fixed physics tick. Define CART_BOOST_EN to build the boost timer.
module cart_motion_controller #(
  parameter int TICK_DIV        = 1000000,
  parameter int ACCEL           = 1,
  parameter int MAX_SPEED       = 4,
  parameter int MAX_SPEED_BOOST = 8,
  parameter int BOOST_TICKS     = 50,
  parameter int X_MAX           = 639,
  parameter int Y_MAX           = 479,
  parameter int X_START         = 320,
  parameter int Y_START         = 400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state,
  input  logic [2:0] operation_code,
  input  logic       boost,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [1:0] heading,
  output logic [4:0] speed,
  output logic       boost_active,
  output logic       tick
);
  localparam logic [2:0] ST_RACING = 3'd4;
  localparam logic [2:0] ST_PAUSE  = 3'd5;
  localparam logic [2:0] ST_FINISH = 3'd6;
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic signed [11:0] XM = 12'(X_MAX);
  localparam logic signed [11:0] YM = 12'(Y_MAX);
  localparam logic signed [7:0] ACC8  = 8'(ACCEL);
  localparam logic signed [7:0] LIM_N = 8'(MAX_SPEED);

  logic [9:0] x_q, x_d, y_q, y_d, x_n, y_n;
  logic [1:0] hd_q, hd_d, hd_n;
  logic [4:0] sp_q, sp_d, sp_n;
  logic [CW-1:0] cnt_q, cnt_d;
  logic tick_q, tick_d;
  logic acc_pend_q, acc_pend_d, acc_up_q, acc_up_d;
  logic turn_pend_q, turn_pend_d, turn_right_q, turn_right_d;
  logic wrap, collide;
  logic signed [11:0] nx, ny, sp12;
  logic signed [7:0] sp8, spw, lim;

  assign wrap = (state == ST_RACING) && (cnt_q == CNT_LAST);

`ifdef CART_BOOST_EN
  localparam int TW = $clog2(BOOST_TICKS + 1);
  localparam logic [TW-1:0] TMR_INIT = TW'(BOOST_TICKS);
  localparam logic signed [7:0] LIM_B = 8'(MAX_SPEED_BOOST);
  logic [TW-1:0] tmr_q, tmr_d, tmr_n;
  logic bpend_q, bpend_d, ba_q;

  // Limit follows the post-update timer so expiry clamps speed on the same tick.
  always_comb begin
    if (bpend_q)             tmr_n = TMR_INIT;
    else if (tmr_q != '0)    tmr_n = tmr_q - 1'b1;
    else                     tmr_n = '0;
  end
  assign lim          = (tmr_n != '0) ? LIM_B : LIM_N;
  assign boost_active = ba_q;
`else
  logic unused_boost;
  assign unused_boost = boost ^ (MAX_SPEED_BOOST > 0) ^ (BOOST_TICKS > 0);
  assign lim          = LIM_N;
  assign boost_active = 1'b0;
`endif

  // Physics result from pre-update registers; committed only on the wrap cycle.
  always_comb begin
    sp12 = {{7{sp_q[4]}}, sp_q};
    nx   = {2'b00, x_q};
    ny   = {2'b00, y_q};
    case (hd_q)
      2'd0:    ny = ny - sp12;
      2'd1:    nx = nx + sp12;
      2'd2:    ny = ny + sp12;
      default: nx = nx - sp12;
    endcase
    collide = 1'b0;
    x_n     = nx[9:0];
    y_n     = ny[9:0];
    if (nx < 0)       begin x_n = '0;       collide = 1'b1; end
    else if (nx > XM) begin x_n = XM[9:0];  collide = 1'b1; end
    if (ny < 0)       begin y_n = '0;       collide = 1'b1; end
    else if (ny > YM) begin y_n = YM[9:0];  collide = 1'b1; end
    hd_n = hd_q;
    if (turn_pend_q) hd_n = turn_right_q ? hd_q + 2'd1 : hd_q - 2'd1;
    sp8 = {{3{sp_q[4]}}, sp_q};
    if (acc_pend_q)   spw = acc_up_q ? sp8 + ACC8 : sp8 - ACC8;
    else if (sp8 > 0) spw = sp8 - 8'sd1;
    else if (sp8 < 0) spw = sp8 + 8'sd1;
    else              spw = sp8;
    if (spw > lim)       spw = lim;
    else if (spw < -lim) spw = -lim;
    sp_n = collide ? 5'd0 : spw[4:0];
  end

  always_comb begin
    x_d = x_q; y_d = y_q; hd_d = hd_q; sp_d = sp_q;
    cnt_d = cnt_q; tick_d = 1'b0;
    acc_pend_d = acc_pend_q; acc_up_d = acc_up_q;
    turn_pend_d = turn_pend_q; turn_right_d = turn_right_q;
`ifdef CART_BOOST_EN
    tmr_d = tmr_q; bpend_d = bpend_q;
`endif
    case (state)
      ST_PAUSE: begin
      end
      ST_FINISH: begin
        sp_d = '0; cnt_d = '0;
        acc_pend_d = 1'b0; turn_pend_d = 1'b0;
`ifdef CART_BOOST_EN
        bpend_d = 1'b0;
`endif
      end
      ST_RACING: begin
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        if (wrap) begin
          x_d = x_n; y_d = y_n; hd_d = hd_n; sp_d = sp_n; tick_d = 1'b1;
          acc_pend_d = 1'b0; turn_pend_d = 1'b0;
`ifdef CART_BOOST_EN
          tmr_d = tmr_n; bpend_d = 1'b0;
`endif
        end
        // Capture after the clear so an event on the wrap cycle lands on the next tick.
        case (operation_code)
          3'd1: begin acc_pend_d  = 1'b1; acc_up_d     = 1'b1; end
          3'd2: begin acc_pend_d  = 1'b1; acc_up_d     = 1'b0; end
          3'd3: begin turn_pend_d = 1'b1; turn_right_d = 1'b0; end
          3'd4: begin turn_pend_d = 1'b1; turn_right_d = 1'b1; end
          default: begin end
        endcase
`ifdef CART_BOOST_EN
        if (boost) bpend_d = 1'b1;
`endif
      end
      default: begin
        x_d = 10'(X_START); y_d = 10'(Y_START); hd_d = '0; sp_d = '0; cnt_d = '0;
        acc_pend_d = 1'b0; turn_pend_d = 1'b0;
`ifdef CART_BOOST_EN
        tmr_d = '0; bpend_d = 1'b0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q <= 10'(X_START); y_q <= 10'(Y_START); hd_q <= '0; sp_q <= '0;
      cnt_q <= '0; tick_q <= 1'b0;
      acc_pend_q <= 1'b0; acc_up_q <= 1'b0; turn_pend_q <= 1'b0; turn_right_q <= 1'b0;
    end else begin
      x_q <= x_d; y_q <= y_d; hd_q <= hd_d; sp_q <= sp_d;
      cnt_q <= cnt_d; tick_q <= tick_d;
      acc_pend_q <= acc_pend_d; acc_up_q <= acc_up_d;
      turn_pend_q <= turn_pend_d; turn_right_q <= turn_right_d;
    end
  end

`ifdef CART_BOOST_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr_q <= '0; bpend_q <= 1'b0; ba_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d; bpend_q <= bpend_d; ba_q <= (tmr_d != '0);
    end
  end
`endif

  assign pos_x   = x_q;
  assign pos_y   = y_q;
  assign heading = hd_q;
  assign speed   = sp_q;
  assign tick    = tick_q;
endmodule

// File: doc/cart_motion_controller.md
Name: cart_motion_controller

Overview:
- Consumes the operation_code/boost event pulses from the operation encoder and integrates them into cart kinematics: heading, signed speed and 2-D position.
- Runs a fixed-rate physics tick. Outputs feed the renderer and the sync/lap logic.
- Gated by the game FSM state: operates only in RACING, frozen in PAUSE, parked at start position otherwise.

Parameters:
- TICK_DIV, 1000000, clk cycles per physics tick (10 ms at 100 MHz); must be >= 2
- ACCEL, 1, speed change per FORWARD/BACKWARD event
- MAX_SPEED, 4, normal |speed| limit
- MAX_SPEED_BOOST, 8, |speed| limit while boost active; must be <= 15
- BOOST_TICKS, 50, ticks a boost lasts
- X_MAX, 639, max x coordinate
- Y_MAX, 479, max y coordinate
- X_START, 320, start x
- Y_START, 400, start y

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- state  in  3  game FSM state: IDLE=0, SETTING=1, SYNCING=2, COUNTDOWN=3, RACING=4, PAUSE=5, FINISH=6
- operation_code  in  3  one-cycle event: NIL=0, FORWARD=1, BACKWARD=2, LEFT=3, RIGHT=4; values 5-7 treated as NIL
- boost  in  1  one-cycle boost event
- pos_x  out  10  cart x
- pos_y  out  10  cart y; y decreases going North
- heading  out  2  0=N, 1=E, 2=S, 3=W
- speed  out  5  signed two's-complement speed; negative = reversing
- boost_active  out  1  boost timer nonzero
- tick  out  1  one-cycle pulse, registered, high in the cycle after a physics update

Behaviour:
- Reset (rst=0, async):
  - pos=(X_START, Y_START), heading=0, speed=0, boost_active=0, tick=0
  - tick counter=0, pending regs cleared
- States IDLE, SETTING, SYNCING, COUNTDOWN:
  - Kinematics forced to reset values each cycle
  - Tick counter cleared; events ignored
- PAUSE:
  - All registers hold, including the tick counter mid-count
  - Events ignored; tick=0
- FINISH:
  - speed forced 0; pos and heading hold
  - Counter cleared; events ignored
- RACING, tick counter:
  - Counts 0..TICK_DIV-1; the physics update fires on the wrap cycle
  - tick is asserted the following cycle
- RACING, event capture into pending registers:
  - FORWARD/BACKWARD → pending_accel = +1/-1; latest event overwrites
  - LEFT/RIGHT → pending_turn = -1/+1; latest overwrites
  - boost → pending_boost = 1
  - Accel, turn and boost pending are independent
- Physics update, all using pre-update register values:
  - pos += old speed along old heading. Each axis is computed in 12-bit signed and clamped to [0, X_MAX] / [0, Y_MAX].
  - If a clamp occurs, speed <= 0 (collision). This overrides the speed rule below.
  - heading <= heading + pending_turn, mod 4
  - If pending_boost, boost timer <= BOOST_TICKS; otherwise the timer decrements, saturating at 0.
  - limit = MAX_SPEED_BOOST if the post-update boost timer is nonzero, else MAX_SPEED.
  - Speed with pending_accel: speed ± ACCEL, saturated to ±limit.
  - Speed without pending_accel: decays 1 toward 0 (friction), then clamped to ±limit. On boost expiry a speed above MAX_SPEED drops straight to ±MAX_SPEED.
  - Pending registers clear.
- Event in the same cycle as the update: the event is not applied this tick. It is captured into pending after the clear (capture wins) and applied next tick.
- boost_active = (boost timer != 0), registered.
- rst asserted mid-race: immediate return to reset values; no partial update.

Optional Feature:
- Macro CART_BOOST_EN.
- Defined: boost input, boost timer and MAX_SPEED_BOOST are implemented as described above.
- Undefined:
  - boost input ignored; boost_active tied to 0
  - limit is always MAX_SPEED
  - no boost timer logic synthesized

Test Plan (TICK_DIV=4, ACCEL=1, MAX_SPEED=4, MAX_SPEED_BOOST=8, BOOST_TICKS=3):
- rst=0 in any state → pos=(320,400), heading=0, speed=0, tick=0. Release with state=IDLE → values held; no tick pulses.
- state=RACING, one FORWARD pulse before each of 5 ticks:
  - speed goes 1,2,3,4,4
  - pos_y goes 400,399,397,394,390
  - then 4 ticks with no events → speed 3,2,1,0
- RIGHT pulse, tick → heading=1. With speed=2, next tick → pos_x 320→322, pos_y unchanged. LEFT ×2 across two ticks → heading=3.
- boost pulse plus FORWARD pulses to speed=8 → boost_active=1. After the timer expires with no events → speed clamps to 4 on the expiry tick and boost_active=0.
- Wall collision: heading=1, pos_x=637, speed=4 → next tick pos_x=639, speed=0. Same test at heading=0, pos_y=2 → pos_y=0, speed=0.
- Mid-count switch to PAUSE:
  - counter, pos and speed frozen for 20 cycles; FORWARD pulses ignored
  - return to RACING → the tick fires after the remaining count
  - FORWARD arriving on the wrap cycle → applied on the following tick
